// File: rtl/main_fsm_pkg.sv
// Shared multicycle-control definitions: state encodings, opcodes, ALU op codes
// and the control-word layout driven by the main FSM.
package main_fsm_pkg;

  localparam int unsigned STATE_BITS = 4;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned CTRL_W     = 15;

  typedef enum logic [STATE_BITS-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Control word of FETCH; also the value the outputs take out of reset.
  localparam ctrl_t CTRL_FETCH = '{pcwrite: 1'b1, irwrite: 1'b1, alusrcb: SRCB_FOUR,
                                   pcsrc: PCSRC_ALU, aluop: ALUOP_ADD, default: '0};

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decode: maps a raw state value to the 15-bit control word.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  logic [STATE_BITS-1:0] state,
  output ctrl_t                 ctrl_c
);

  // Unencoded values fall through to an all-zero word.
  always_comb begin
    ctrl_c = '0;
    case (state)
      FETCH:   ctrl_c = CTRL_FETCH;
      DECODE: begin
        ctrl_c.alusrcb = SRCB_IMMSH;
        ctrl_c.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = SRCB_IMM;
      end
      MEMRD:   ctrl_c.iord = 1'b1;
      MEMWB: begin
        ctrl_c.memtoreg = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = SRCB_REG;
        ctrl_c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_c.regdst   = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.aluop   = ALUOP_SUB;
        ctrl_c.pcsrc   = PCSRC_ALUOUT;
        ctrl_c.branch  = 1'b1;
      end
      ADDIWB:  ctrl_c.regwrite = 1'b1;
      JUMP: begin
        ctrl_c.pcwrite = 1'b1;
        ctrl_c.pcsrc   = PCSRC_JUMP;
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back steps from the instruction opcode.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  output logic               pcwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               branch,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state logic; op only matters in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Decoding the next state lets the control word be registered while still
  // always matching the current state.
  main_fsm_outdec u_outdec (
    .state  (state_d),
    .ctrl_c (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign pcwrite  = ctrl_q.pcwrite;
  assign memwrite = ctrl_q.memwrite;
  assign irwrite  = ctrl_q.irwrite;
  assign regwrite = ctrl_q.regwrite;
  assign alusrca  = ctrl_q.alusrca;
  assign branch   = ctrl_q.branch;
  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign aluop    = ctrl_q.aluop;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Directed self-checking bench for main_fsm: per-cycle state and control-word
// checks for each instruction class, reset behaviour and op independence.
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Observed control word: pcw,memw,irw,regw,srca,br,iord,m2r,rdst,srcb,pcsrc,aluop
  logic [14:0] obs;
  assign obs = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg,
                regdst, alusrcb, pcsrc, aluop};

  localparam logic [14:0] C_FETCH   = 15'b101000000_01_00_00;
  localparam logic [14:0] C_DECODE  = 15'b000000000_11_00_00;
  localparam logic [14:0] C_MEMADR  = 15'b000010000_10_00_00;
  localparam logic [14:0] C_MEMRD   = 15'b000000100_00_00_00;
  localparam logic [14:0] C_MEMWB   = 15'b000100010_00_00_00;
  localparam logic [14:0] C_MEMWR   = 15'b010000100_00_00_00;
  localparam logic [14:0] C_EXECUTE = 15'b000010000_00_00_10;
  localparam logic [14:0] C_ALUWB   = 15'b000100001_00_00_00;
  localparam logic [14:0] C_BRANCH  = 15'b000011000_00_01_01;
  localparam logic [14:0] C_ADDIWB  = 15'b000100000_00_00_00;
  localparam logic [14:0] C_JUMP    = 15'b100000000_00_10_00;

  main_fsm #(.STATE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .pcwrite  (pcwrite),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .branch   (branch),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 6'b100011;
    step();
    step();
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (obs !== C_FETCH) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected %b", obs, C_FETCH);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  es [6];
    logic [14:0] ec [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ec = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== es[i]) begin
        n_errors++;
        $display("FAIL lw_state cyc%0d: got %0d expected %0d", i + 1, state, es[i]);
      end
      n_checks++;
      if (obs !== ec[i]) begin
        n_errors++;
        $display("FAIL lw_ctrl cyc%0d: got %b expected %b", i + 1, obs, ec[i]);
      end
      // op changes while in MEMRD must not disturb the sequence
      if (i == 3) op = 6'b000100;
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [5];
    logic [14:0] ec [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    ec = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== es[i]) begin
        n_errors++;
        $display("FAIL sw_state cyc%0d: got %0d expected %0d", i + 1, state, es[i]);
      end
      n_checks++;
      if (obs !== ec[i]) begin
        n_errors++;
        $display("FAIL sw_ctrl cyc%0d: got %b expected %b", i + 1, obs, ec[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0]  es [4];
    logic [14:0] ec [4];
    es = '{4'd0, 4'd1, 4'd8, 4'd0};
    ec = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH};
    op = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== es[i]) begin
        n_errors++;
        $display("FAIL beq_state cyc%0d: got %0d expected %0d", i + 1, state, es[i]);
      end
      n_checks++;
      if (obs !== ec[i]) begin
        n_errors++;
        $display("FAIL beq_ctrl cyc%0d: got %b expected %b", i + 1, obs, ec[i]);
      end
    end
  endtask

  task automatic test_undefined();
    logic [3:0]  es [3];
    logic [14:0] ec [3];
    es = '{4'd0, 4'd1, 4'd0};
    ec = '{C_FETCH, C_DECODE, C_FETCH};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== es[i]) begin
        n_errors++;
        $display("FAIL undef_state cyc%0d: got %0d expected %0d", i + 1, state, es[i]);
      end
      n_checks++;
      if (obs !== ec[i]) begin
        n_errors++;
        $display("FAIL undef_ctrl cyc%0d: got %b expected %b", i + 1, obs, ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  es [8];
    logic [14:0] ec [8];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd11, 4'd0};
    ec = '{C_FETCH, C_DECODE, C_EXECUTE, C_ALUWB, C_FETCH, C_DECODE, C_JUMP, C_FETCH};
    op = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== es[i]) begin
        n_errors++;
        $display("FAIL b2b_state cyc%0d: got %0d expected %0d", i + 1, state, es[i]);
      end
      n_checks++;
      if (obs !== ec[i]) begin
        n_errors++;
        $display("FAIL b2b_ctrl cyc%0d: got %b expected %b", i + 1, obs, ec[i]);
      end
      if (i == 4) op = 6'b000010;
    end
  endtask

  task automatic test_addi();
    logic [3:0]  es [5];
    logic [14:0] ec [5];
    es = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    ec = '{C_FETCH, C_DECODE, C_MEMADR, C_ADDIWB, C_FETCH};
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== es[i]) begin
        n_errors++;
        $display("FAIL addi_state cyc%0d: got %0d expected %0d", i + 1, state, es[i]);
      end
      n_checks++;
      if (obs !== ec[i]) begin
        n_errors++;
        $display("FAIL addi_ctrl cyc%0d: got %b expected %b", i + 1, obs, ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011;
    step();
    step();
    step();
    n_checks++;
    if (state !== 4'd3) begin
      n_errors++;
      $display("FAIL rstmid_pre: got %0d expected 3", state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++;
      $display("FAIL rstmid_state: got %0d expected 0", state);
    end
    n_checks++;
    if (obs !== C_FETCH) begin
      n_errors++;
      $display("FAIL rstmid_ctrl: got %b expected %b", obs, C_FETCH);
    end
    step();
    n_checks++;
    if (state !== 4'd1) begin
      n_errors++;
      $display("FAIL rstmid_resume: got %0d expected 1", state);
    end
    op = 6'b111111;
    step();
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++;
      $display("FAIL rstmid_end: got %0d expected 0", state);
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_undefined();
    test_back_to_back();
    test_addi();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
